// File: rtl/alu_exec_pkg.sv
// Shared definitions for the ALU execute stage.
// Holds the operation-kind encodings, the ALU opcode constants, the status codes
// written to the status register on an overflow exception, and the layout of one
// result entry as stored in the stage's output buffer.
package alu_exec_pkg;

    // Operation kind, as presented on in_kind.
    typedef enum logic [1:0] {
        KindRtype = 2'b00,
        KindAddi  = 2'b01,
        KindBne   = 2'b10,
        KindBlt   = 2'b11
    } kind_e;

    // ALU opcodes, as presented on in_alu_op.
    localparam logic [4:0] AluOpAdd = 5'b00000;
    localparam logic [4:0] AluOpSub = 5'b00001;
    localparam logic [4:0] AluOpAnd = 5'b00010;
    localparam logic [4:0] AluOpOr  = 5'b00011;
    localparam logic [4:0] AluOpSll = 5'b00100;
    localparam logic [4:0] AluOpSra = 5'b00101;

    // Status codes written on an overflow exception.
    localparam logic [31:0] RstatusAddOvf  = 32'd1;
    localparam logic [31:0] RstatusAddiOvf = 32'd2;
    localparam logic [31:0] RstatusSubOvf  = 32'd3;

    // One buffered result.
    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        we;
        logic        taken;
    } entry_t;

endpackage

// File: rtl/alu.sv
// Combinational team ALU.
// Ports:
//   a_i, b_i        32-bit operands
//   op_i            opcode (add, sub, and, or, sll, sra); unknown opcodes give 0
//   shamt_i         shift amount for sll/sra (shifts operand A)
//   result_o        32-bit result, wrapping modulo 2^32
//   overflow_o      signed overflow of add/sub; 0 for other opcodes
//   is_not_equal_o  a_i != b_i
//   is_less_than_o  signed a_i < b_i
module alu
    import alu_exec_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [4:0]  op_i,
    input  logic [4:0]  shamt_i,
    output logic [31:0] result_o,
    output logic        overflow_o,
    output logic        is_not_equal_o,
    output logic        is_less_than_o
);

    logic [31:0] sum;
    logic [31:0] diff;

    assign sum  = a_i + b_i;
    assign diff = a_i - b_i;

    assign is_not_equal_o = (a_i != b_i);
    assign is_less_than_o = ($signed(a_i) < $signed(b_i));

    always_comb begin
        result_o   = '0;
        overflow_o = 1'b0;
        case (op_i)
            AluOpAdd: begin
                result_o   = sum;
                // Like-signed operands producing an opposite-signed sum.
                overflow_o = (a_i[31] == b_i[31]) && (sum[31] != a_i[31]);
            end
            AluOpSub: begin
                result_o   = diff;
                // Unlike-signed operands where the difference flips away from A.
                overflow_o = (a_i[31] != b_i[31]) && (diff[31] != a_i[31]);
            end
            AluOpAnd: result_o = a_i & b_i;
            AluOpOr:  result_o = a_i | b_i;
            AluOpSll: result_o = a_i << shamt_i;
            AluOpSra: result_o = $signed(a_i) >>> shamt_i;
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec_stage.sv
// ALU execute stage with a 2-entry output skid buffer.
// Runs the ALU on the incoming operands, shapes the result by operation kind
// (register write, branch decision) and queues it for the downstream stage.
// Optional feature: define ALU_EXEC_OVF_EXCEPT_EN to redirect overflowing
// add/addi/sub results to register RSTATUS_REG with a status code; otherwise
// the wrapped result goes to in_rd and the overflow flag is ignored.
// Ports:
//   clock, reset_n                  clock and asynchronous active-low reset
//   in_valid / in_ready             upstream handshake (in_ready from registered count)
//   in_a, in_b, in_alu_op, in_shamt ALU operands and opcode
//   in_kind, in_rd                  operation kind and destination register
//   flush                           synchronous discard of all buffered entries
//   out_valid / out_ready           downstream handshake
//   out_result, out_rd, out_we, out_taken  head entry of the buffer (0 when empty)
module alu_exec_stage
    import alu_exec_pkg::*;
#(
    parameter int unsigned RSTATUS_REG = 30
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [4:0]  in_alu_op,
    input  logic [4:0]  in_shamt,
    input  logic [1:0]  in_kind,
    input  logic [4:0]  in_rd,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_rd,
    output logic        out_we,
    output logic        out_taken
);

    localparam logic [4:0] RstatusRd = RSTATUS_REG[4:0];

    logic [31:0] alu_result;
    logic        alu_overflow;
    logic        alu_ne;
    logic        alu_lt;

    alu u_alu (
        .a_i            (in_a),
        .b_i            (in_b),
        .op_i           (in_alu_op),
        .shamt_i        (in_shamt),
        .result_o       (alu_result),
        .overflow_o     (alu_overflow),
        .is_not_equal_o (alu_ne),
        .is_less_than_o (alu_lt)
    );

`ifndef ALU_EXEC_OVF_EXCEPT_EN
    logic unused_overflow;
    assign unused_overflow = alu_overflow;
`endif

    // Shape the ALU outcome into the entry that will be queued.
    entry_t new_entry;

    always_comb begin
        new_entry        = '0;
        new_entry.rd     = in_rd;
        case (in_kind)
            KindRtype, KindAddi: begin
                new_entry.we     = 1'b1;
                new_entry.result = alu_result;
`ifdef ALU_EXEC_OVF_EXCEPT_EN
                if (alu_overflow) begin
                    new_entry.rd = RstatusRd;
                    if (in_kind == KindAddi) begin
                        new_entry.result = RstatusAddiOvf;
                    end else if (in_alu_op == AluOpSub) begin
                        new_entry.result = RstatusSubOvf;
                    end else begin
                        new_entry.result = RstatusAddOvf;
                    end
                end
`endif
            end
            KindBne: new_entry.taken = alu_ne;
            KindBlt: new_entry.taken = alu_lt;
            default: new_entry = '0;
        endcase
        // Register 0 is never written, even by the exception rewrite.
        if (new_entry.rd == 5'd0) begin
            new_entry.we = 1'b0;
        end
    end

    // Two-entry circular buffer.
    entry_t     mem_q [2];
    entry_t     mem_d [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       push;
    logic       pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = new_entry;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Outputs read zero whenever the buffer is empty, including during reset.
    entry_t head;

    always_comb begin
        head = '0;
        if (out_valid) begin
            head = mem_q[rd_ptr_q];
        end
    end

    assign out_result = head.result;
    assign out_rd     = head.rd;
    assign out_we     = head.we;
    assign out_taken  = head.taken;

endmodule

// File: tb/tb_alu_exec_stage.sv
module tb_alu_exec_stage;

    localparam int unsigned RstatusReg = 30;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_alu_op;
    logic [4:0]  in_shamt;
    logic [1:0]  in_kind;
    logic [4:0]  in_rd;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_we;
    logic        out_taken;

    alu_exec_stage #(
        .RSTATUS_REG (RstatusReg)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_alu_op  (in_alu_op),
        .in_shamt   (in_shamt),
        .in_kind    (in_kind),
        .in_rd      (in_rd),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .out_we     (out_we),
        .out_taken  (out_taken)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: expected entries in acceptance order.
    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        we;
        logic        taken;
        bit          is_wb;
    } exp_t;

    exp_t exp_q[$];

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] op, input logic [4:0] shamt,
                                   input logic [1:0] kind, input logic [4:0] rd);
        exp_t   e;
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint wide = 0;
        bit     ovf = 0;
        logic [31:0] r = '0;
        case (op)
            5'd0: wide = sa + sb;
            5'd1: wide = sa - sb;
            default: wide = 0;
        endcase
        if (op == 5'd0 || op == 5'd1) begin
            r   = wide[31:0];
            // True value does not fit in 32-bit two's complement.
            ovf = (wide != longint'($signed(r)));
        end
        case (op)
            5'd2: r = a & b;
            5'd3: r = a | b;
            5'd4: r = a << shamt;
            5'd5: r = $signed(a) >>> shamt;
            default: ;
        endcase
        e.result = '0;
        e.rd     = rd;
        e.we     = 1'b0;
        e.taken  = 1'b0;
        e.is_wb  = (kind < 2);
        if (kind < 2) begin
            e.result = r;
`ifdef ALU_EXEC_OVF_EXCEPT_EN
            if (ovf) begin
                e.rd = RstatusReg[4:0];
                if (kind == 1) e.result = 32'd2;
                else if (op == 5'd0) e.result = 32'd1;
                else e.result = 32'd3;
            end
`endif
            e.we = (e.rd != 5'd0);
        end else if (kind == 2) begin
            e.taken = (a != b);
        end else begin
            e.taken = (sa < sb);
        end
        return e;
    endfunction

    // Compare the DUT against the model, advance the model with the current
    // inputs, then step past the next rising edge.
    task automatic cycle();
        int  n;
        bit  do_push;
        bit  do_pop;
        n = exp_q.size();
        check_eq("in_ready", {31'd0, in_ready}, {31'd0, n != 2});
        check_eq("out_valid", {31'd0, out_valid}, {31'd0, n != 0});
        if (n != 0) begin
            check_eq("out_result", out_result, exp_q[0].result);
            check_eq("out_we", {31'd0, out_we}, {31'd0, exp_q[0].we});
            check_eq("out_taken", {31'd0, out_taken}, {31'd0, exp_q[0].taken});
            if (exp_q[0].is_wb) check_eq("out_rd", {27'd0, out_rd}, {27'd0, exp_q[0].rd});
        end
        if (flush) begin
            exp_q.delete();
        end else begin
            do_pop  = out_ready && (n != 0);
            do_push = in_valid && (n != 2);
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(model(in_a, in_b, in_alu_op, in_shamt, in_kind, in_rd));
        end
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                         input logic [1:0] kind, input logic [4:0] rd);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_alu_op = op;
        in_shamt  = 5'd0;
        in_kind   = kind;
        in_rd     = rd;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'd1;
            3: return 32'hFFFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        reset_n   = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_alu_op = '0;
        in_shamt  = '0;
        in_kind   = '0;
        in_rd     = '0;
        flush     = 1'b0;
        out_ready = 1'b1;

        // Asynchronous reset takes effect before any clock edge.
        #2 reset_n = 1'b0;
        #1;
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_out_result", out_result, 32'd0);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        cycle();

        // add 5+7 -> 12 at rd 4, one cycle after acceptance.
        drive(32'd5, 32'd7, 5'd0, 2'b00, 5'd4);
        cycle();
        in_valid = 1'b0;
        check_eq("add_valid", {31'd0, out_valid}, 32'd1);
        check_eq("add_result", out_result, 32'd12);
        check_eq("add_rd", {27'd0, out_rd}, 32'd4);
        check_eq("add_we", {31'd0, out_we}, 32'd1);
        cycle();

        // add overflow.
        drive(32'h7FFF_FFFF, 32'd1, 5'd0, 2'b00, 5'd4);
        cycle();
        in_valid = 1'b0;
`ifdef ALU_EXEC_OVF_EXCEPT_EN
        check_eq("add_ovf_rd", {27'd0, out_rd}, 32'd30);
        check_eq("add_ovf_result", out_result, 32'd1);
`else
        check_eq("add_ovf_rd", {27'd0, out_rd}, 32'd4);
        check_eq("add_ovf_result", out_result, 32'h8000_0000);
`endif
        cycle();

        // sub overflow, then addi overflow.
        drive(32'h8000_0000, 32'd1, 5'd1, 2'b00, 5'd5);
        cycle();
        in_valid = 1'b0;
`ifdef ALU_EXEC_OVF_EXCEPT_EN
        check_eq("sub_ovf_rd", {27'd0, out_rd}, 32'd30);
        check_eq("sub_ovf_result", out_result, 32'd3);
`else
        check_eq("sub_ovf_result", out_result, 32'h7FFF_FFFF);
`endif
        cycle();
        drive(32'h7FFF_FFFF, 32'd1, 5'd0, 2'b01, 5'd6);
        cycle();
        in_valid = 1'b0;
`ifdef ALU_EXEC_OVF_EXCEPT_EN
        check_eq("addi_ovf_result", out_result, 32'd2);
`else
        check_eq("addi_ovf_result", out_result, 32'h8000_0000);
`endif
        cycle();

        // Branches.
        drive(32'hFFFF_FFFF, 32'd2, 5'd1, 2'b11, 5'd7);
        cycle();
        in_valid = 1'b0;
        check_eq("blt_taken", {31'd0, out_taken}, 32'd1);
        check_eq("blt_we", {31'd0, out_we}, 32'd0);
        cycle();
        drive(32'd9, 32'd9, 5'd1, 2'b10, 5'd7);
        cycle();
        in_valid = 1'b0;
        check_eq("bne_taken", {31'd0, out_taken}, 32'd0);
        cycle();

        // Stall: three pushes offered, two accepted, then drain in order.
        out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            drive(i, i, 5'd0, 2'b00, 5'd8 + 5'(i));
            cycle();
        end
        check_eq("stall_in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("stall_head", out_result, 32'd2);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycle();
        check_eq("drain_second", out_result, 32'd4);
        cycle();
        check_eq("drain_empty", {31'd0, out_valid}, 32'd0);

        // Flush with a full buffer and a same-cycle push.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(32'd100 + i, 32'd1, 5'd0, 2'b00, 5'd3);
            cycle();
        end
        flush = 1'b1;
        drive(32'd50, 32'd50, 5'd0, 2'b00, 5'd3);
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_eq("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("flush_in_ready", {31'd0, in_ready}, 32'd1);

        // Reset pulse in the middle of a stall.
        for (int i = 0; i < 2; i++) begin
            drive(32'd200 + i, 32'd3, 5'd0, 2'b00, 5'd9);
            cycle();
        end
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("mid_rst_result", out_result, 32'd0);
        check_eq("mid_rst_rd", {27'd0, out_rd}, 32'd0);
        check_eq("mid_rst_we", {31'd0, out_we}, 32'd0);
        check_eq("mid_rst_taken", {31'd0, out_taken}, 32'd0);
        exp_q.delete();
        @(posedge clock);
        #1 reset_n = 1'b1;
        cycle();
        check_eq("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 39) == 0);
            in_a      = pick_operand();
            in_b      = pick_operand();
            in_alu_op = 5'($urandom_range(0, 5));
            in_shamt  = 5'($urandom_range(0, 31));
            in_kind   = 2'($urandom_range(0, 3));
            in_rd     = 5'($urandom_range(0, 31));
            cycle();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (3) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_exec_stage.md
ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 SHALL have parameter RSTATUS_REG, default 30, meaning the register index written on an overflow exception.
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, upstream operation present.
REQ-005 SHALL have port in_ready, output, 1, stage can accept this cycle.
REQ-006 SHALL have port in_a, input, 32, ALU operand A.
REQ-007 SHALL have port in_b, input, 32, ALU operand B or sign-extended immediate.
REQ-008 SHALL have port in_alu_op, input, 5, ALU opcode: 00000 add, 00001 sub, 00010 and, 00011 or, 00100 sll, 00101 sra.
REQ-009 SHALL have port in_shamt, input, 5, shift amount.
REQ-010 SHALL have port in_kind, input, 2, operation kind: 00 R-type, 01 addi, 10 bne, 11 blt.
REQ-011 SHALL have port in_rd, input, 5, destination register index.
REQ-012 SHALL have port flush, input, 1, synchronous discard of all in-flight entries.
REQ-013 SHALL have ports out_valid (output, 1, result present) and out_ready (input, 1, downstream accepts).
REQ-014 SHALL have ports out_result (output, 32), out_rd (output, 5), out_we (output, 1, register write enable) and out_taken (output, 1, branch taken).

Function
REQ-015 SHALL instantiate the team ALU combinationally on the in_* operands and capture its result and flags into a 2-entry FIFO skid buffer on acceptance (in_valid && in_ready).
REQ-016 SHALL present a captured entry on out_* exactly 1 cycle after acceptance when the buffer was empty; entries SHALL leave in acceptance order.
REQ-017 SHALL drive in_ready = (count != 2), decoded only from registered state.
REQ-018 SHALL pop an entry on out_valid && out_ready; out_* SHALL hold stable while out_valid && !out_ready.
REQ-019 SHALL allow a push and a pop in the same cycle at any count; count SHALL be unchanged and order preserved.
REQ-020 SHALL, for kind 00/01, set out_we=1, out_rd=in_rd, out_result=ALU result and out_taken=0.
REQ-021 SHALL, for kind 10, set out_taken=isNotEqual; for kind 11, set out_taken=isLessThan; out_we=0 and out_result=0 for both.
REQ-022 SHALL, on ALU overflow with kind 00 and op add, set out_rd=RSTATUS_REG and out_result=1; with kind 01, set out_result=2; with kind 00 and op sub, set out_result=3.
REQ-023 SHALL force out_we=0 whenever out_rd=0, including the exception case when RSTATUS_REG=0.
REQ-024 SHALL, on flush, set count to 0 at the next edge and ignore any same-cycle push; flush SHALL override push and pop.
REQ-025 SHALL treat all arithmetic as 32-bit two's complement; sums wrap modulo 2^32.

Reset
REQ-026 SHALL, while reset_n=0, force count=0, out_valid=0, and out_result, out_rd, out_we and out_taken to 0, independent of clock.
REQ-027 SHALL discard in-flight entries on reset asserted mid-operation; in_ready SHALL read 1 from the first edge after release.

Configuration
REQ-028 SHALL implement the overflow exception rewrite of REQ-022 only when macro ALU_EXEC_OVF_EXCEPT_EN is defined.
REQ-029 SHALL, without ALU_EXEC_OVF_EXCEPT_EN, write the wrapped sum to in_rd and ignore the overflow flag.

Structure
REQ-030 SHALL take kind encodings, ALU opcode constants and rstatus codes (1, 2, 3) from shared package alu_exec_pkg.
REQ-031 SHALL contain exactly one sub-module, the existing combinational ALU named alu, instantiated once.

Verification
REQ-032 SHALL cover: add 5+7, rd=4, out_ready=1 -> one cycle later out_valid=1, out_result=12, out_rd=4, out_we=1.
REQ-033 SHALL cover: add 0x7FFFFFFF+1, rd=4, macro defined -> out_rd=30, out_result=1; macro undefined -> out_rd=4, out_result=0x80000000.
REQ-034 SHALL cover: sub 0x80000000-1 -> out_result=3 at rd 30; addi overflow -> out_result=2.
REQ-035 SHALL cover: out_ready=0 with 3 pushes offered -> in_ready=0 after 2 pushes, outputs stable; release -> results drain in order.
REQ-036 SHALL cover: blt a=-1, b=2 -> out_taken=1, out_we=0; bne a=b=9 -> out_taken=0.
REQ-037 SHALL cover: count=2 with flush and in_valid in the same cycle -> next cycle out_valid=0 and in_ready=1; reset_n pulse mid-stall -> all outputs 0 at once.
